// File: rtl/instr_register_pkg.sv
// Shared instruction-register types plus the execute-stage state and result types.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic        [4:0]  address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC    = 3'd2,
    S_DIVWAIT = 3'd3,
    S_OUT     = 3'd4
  } exec_state_t;

  typedef logic signed [63:0] result_t;

endpackage

// File: rtl/instr_divider.sv
// Signed restoring divider: magnitudes in, 32 shift/subtract iterations, signs restored on output.
// Quotient truncates toward zero; the remainder takes the sign of the dividend.
module instr_divider
  import instr_register_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     div_start,
  input  operand_t dividend,
  input  operand_t divisor,
  output result_t  quotient,
  output result_t  remainder,
  output logic     div_done
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [4:0]  cnt_q;
  logic        run_q;
  logic        q_neg_q;
  logic        r_neg_q;

  logic [32:0] shifted;
  logic [33:0] trial;
  logic        step_ok;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;

  function automatic logic [31:0] magnitude(input operand_t v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  function automatic result_t apply_sign(input logic [31:0] mag, input logic neg);
    result_t m;
    m = {32'd0, mag};
    return neg ? -m : m;
  endfunction

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};
    step_ok = !trial[33];
    rem_nx  = step_ok ? trial[31:0] : shifted[31:0];
    quo_nx  = {quo_q[30:0], step_ok};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_done  <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        rem_q   <= '0;
        quo_q   <= magnitude(dividend);
        dvs_q   <= magnitude(divisor);
        q_neg_q <= dividend[31] ^ divisor[31];
        r_neg_q <= dividend[31];
        cnt_q   <= '0;
        run_q   <= 1'b1;
      end else if (run_q) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q + 5'd1;
        // Final iteration: publish signed results together with the done pulse.
        if (cnt_q == 5'd31) begin
          run_q     <= 1'b0;
          div_done  <= 1'b1;
          quotient  <= apply_sign(quo_nx, q_neg_q);
          remainder <= apply_sign(rem_nx, r_neg_q);
        end
      end
    end
  end

endmodule

// File: rtl/instr_exec_unit.sv
// Execute stage walking a run of instruction-register entries, one valid/ready result per entry.
// Optional macro DIV_ZERO_TRAP_EN: a divide by zero ends the run after its errored result.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  address_t     start_ptr,
  input  logic [5:0]   count,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic         res_valid,
  input  logic         res_ready,
  output result_t      res_value,
  output opcode_t      res_opcode,
  output address_t     res_ptr,
  output logic         res_err,
  output logic         busy,
  output logic         done
);

  localparam address_t PTR_MASK = address_t'(DEPTH - 1);

  exec_state_t  state_q, state_d;
  instruction_t iw_q;
  logic [5:0]   remaining;

  result_t op_a64, op_b64;
  result_t exec_val;
  logic    exec_err;
  logic    exec_is_div;
  logic    div_go;
  logic    div_start;
  logic    div_done;
  result_t quotient, remainder;
  logic    handshake;
  logic    abort;
  logic    last_result;

  instr_divider u_divider (
    .clk       (clk),
    .reset_n   (reset_n),
    .div_start (div_start),
    .dividend  (iw_q.op_a),
    .divisor   (iw_q.op_b),
    .quotient  (quotient),
    .remainder (remainder),
    .div_done  (div_done)
  );

  // Single-cycle result of the fetched word; DIV/MOD only flag themselves here.
  always_comb begin
    op_a64      = {{32{iw_q.op_a[31]}}, iw_q.op_a};
    op_b64      = {{32{iw_q.op_b[31]}}, iw_q.op_b};
    exec_val    = '0;
    exec_err    = 1'b0;
    exec_is_div = 1'b0;
    case (iw_q.opc)
      ZERO:    exec_val = '0;
      PASSA:   exec_val = op_a64;
      PASSB:   exec_val = op_b64;
      ADD:     exec_val = op_a64 + op_b64;
      SUB:     exec_val = op_a64 - op_b64;
      MULT:    exec_val = op_a64 * op_b64;
      DIV, MOD: begin
        exec_is_div = 1'b1;
        exec_err    = (iw_q.op_b == '0);
      end
      default: exec_err = 1'b1;
    endcase
  end

  assign div_go = exec_is_div && !exec_err;

`ifdef DIV_ZERO_TRAP_EN
  assign abort = res_err && ((res_opcode == DIV) || (res_opcode == MOD));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    busy        = (state_q != S_IDLE);
    res_valid   = (state_q == S_OUT);
    div_start   = (state_q == S_EXEC) && div_go;
    handshake   = res_valid && res_ready;
    last_result = (remaining == 6'd1) || abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && (count != 6'd0)) state_d = S_FETCH;
      S_FETCH:   state_d = S_EXEC;
      S_EXEC:    state_d = div_go ? S_DIVWAIT : S_OUT;
      S_DIVWAIT: if (div_done) state_d = S_OUT;
      S_OUT:     if (handshake) state_d = last_result ? S_IDLE : S_FETCH;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath registers; result fields only change on entry to OUT, so they hold under stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_pointer <= '0;
      remaining    <= '0;
      iw_q         <= '0;
      res_value    <= '0;
      res_opcode   <= ZERO;
      res_ptr      <= '0;
      res_err      <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && (count != 6'd0)) begin
            read_pointer <= start_ptr;
            remaining    <= count;
          end else if (start) begin
            done <= 1'b1;
          end
        end
        S_FETCH: iw_q <= instruction_word;
        S_EXEC: begin
          res_opcode <= iw_q.opc;
          res_ptr    <= read_pointer;
          if (!div_go) begin
            res_value <= exec_val;
            res_err   <= exec_err;
          end
        end
        S_DIVWAIT: begin
          if (div_done) begin
            res_value <= (iw_q.opc == DIV) ? quotient : remainder;
            res_err   <= 1'b0;
          end
        end
        S_OUT: begin
          if (handshake) begin
            if (last_result) begin
              remaining <= '0;
              done      <= 1'b1;
            end else begin
              remaining    <= remaining - 6'd1;
              read_pointer <= (read_pointer + 5'd1) & PTR_MASK;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_exec_unit.sv
// Directed bench for instr_exec_unit with a behavioural instruction register.
module tb_instr_exec_unit;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  address_t     start_ptr = '0;
  logic [5:0]   count = '0;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic         res_valid;
  logic         res_ready = 1'b1;
  result_t      res_value;
  opcode_t      res_opcode;
  address_t     res_ptr;
  logic         res_err;
  logic         busy;
  logic         done;

  instruction_t mem [32];
  int total = 0;
  int bad = 0;
  int n;

  assign instruction_word = mem[read_pointer];

  instr_exec_unit #(.DEPTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_ptr        (start_ptr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_value        (res_value),
    .res_opcode       (res_opcode),
    .res_ptr          (res_ptr),
    .res_err          (res_err),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input address_t p, input logic [5:0] c);
    start     = 1'b1;
    start_ptr = p;
    count     = c;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for res_valid; n returns the number of edges it took.
  task automatic wait_valid(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (!res_valid && cycles < limit) begin
      step();
      cycles++;
    end
    chk({tag, "_timeout"}, res_valid, 1'b1);
  endtask

  task automatic set_word(input int idx, input opcode_t op, input operand_t a, input operand_t b);
    mem[idx].opc  = op;
    mem[idx].op_a = a;
    mem[idx].op_b = b;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    set_word(3, ADD, 32'sd5, 32'sd7);
    set_word(4, SUB, 32'sd2, 32'sd9);
    set_word(5, MULT, -32'sd3, 32'sd4);
    set_word(10, DIV, 32'sd7, -32'sd2);
    set_word(11, MOD, -32'sd7, 32'sd2);
    set_word(12, DIV, 32'sh8000_0000, -32'sd1);
    set_word(14, DIV, 32'sd10, 32'sd0);
    set_word(15, ADD, 32'sd1, 32'sd1);
    set_word(16, SUB, 32'sd5, 32'sd1);
    mem[17].opc = opcode_t'(4'd9);
    mem[17].op_a = 32'sd3;
    mem[17].op_b = 32'sd4;
    set_word(30, PASSA, 32'sd100, 32'sd0);
    set_word(31, PASSB, 32'sd0, -32'sd5);
    set_word(0, ZERO, 32'sd9, 32'sd9);
    set_word(1, ADD, -32'sd1, -32'sd1);

    // Reset state
    step();
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rp", read_pointer, 5'd0);
    chk("rst_value", res_value, 64'd0);
    reset_n = 1'b1;
    step();

    // ADD/SUB/MULT run from entry 3
    kick(5'd3, 6'd3);
    chk("r1_busy", busy, 1'b1);
    chk("r1_rp", read_pointer, 5'd3);
    wait_valid("r1a", 10, n);
    chk("r1a_lat", n, 2);
    chk("r1a_val", res_value, 64'sd12);
    chk("r1a_ptr", res_ptr, 5'd3);
    chk("r1a_op", res_opcode, ADD);
    chk("r1a_err", res_err, 1'b0);
    step();
    chk("r1_nodone", done, 1'b0);
    wait_valid("r1b", 10, n);
    chk("r1b_lat", n, 2);
    chk("r1b_val", res_value, -64'sd7);
    chk("r1b_ptr", res_ptr, 5'd4);
    step();
    wait_valid("r1c", 10, n);
    chk("r1c_val", res_value, -64'sd12);
    chk("r1c_ptr", res_ptr, 5'd5);
    step();
    chk("r1_done", done, 1'b1);
    chk("r1_idle", busy, 1'b0);
    step();
    chk("r1_done_pulse", done, 1'b0);

    // Divider run: 7/-2, -7 mod 2, MIN_INT/-1
    kick(5'd10, 6'd3);
    wait_valid("r2a", 60, n);
    chk("r2a_lat", n, 35);
    chk("r2a_val", res_value, -64'sd3);
    chk("r2a_op", res_opcode, DIV);
    chk("r2a_err", res_err, 1'b0);
    step();
    wait_valid("r2b", 60, n);
    chk("r2b_lat", n, 35);
    chk("r2b_val", res_value, -64'sd1);
    chk("r2b_op", res_opcode, MOD);
    step();
    wait_valid("r2c", 60, n);
    chk("r2c_val", res_value, 64'sd2147483648);
    chk("r2c_err", res_err, 1'b0);
    step();
    chk("r2_done", done, 1'b1);
    step();

    // Divide by zero
    kick(5'd14, 6'd3);
    wait_valid("r3a", 60, n);
    chk("r3a_lat", n, 2);
    chk("r3a_val", res_value, 64'd0);
    chk("r3a_err", res_err, 1'b1);
    step();
`ifdef DIV_ZERO_TRAP_EN
    chk("r3_trap_done", done, 1'b1);
    chk("r3_trap_idle", busy, 1'b0);
`else
    chk("r3_cont_busy", busy, 1'b1);
    wait_valid("r3b", 10, n);
    chk("r3b_val", res_value, 64'sd2);
    chk("r3b_err", res_err, 1'b0);
    step();
    wait_valid("r3c", 10, n);
    chk("r3c_val", res_value, 64'sd4);
    step();
    chk("r3_done", done, 1'b1);
`endif
    step();

    // Illegal opcode
    kick(5'd17, 6'd1);
    wait_valid("r4", 10, n);
    chk("r4_val", res_value, 64'd0);
    chk("r4_err", res_err, 1'b1);
    chk("r4_op", res_opcode, 64'd9);
    step();
    chk("r4_done", done, 1'b1);
    step();

    // Wrap-around run with back-pressure and an ignored start
    res_ready = 1'b0;
    kick(5'd30, 6'd4);
    chk("r5_rp0", read_pointer, 5'd30);
    wait_valid("r5a", 10, n);
    chk("r5a_val", res_value, 64'sd100);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      start_ptr = 5'd7;
      count = 6'd1;
      step();
      start = 1'b0;
      chk("r5_stall_valid", res_valid, 1'b1);
      chk("r5_stall_val", res_value, 64'sd100);
      chk("r5_stall_ptr", res_ptr, 5'd30);
      chk("r5_stall_rp", read_pointer, 5'd30);
    end
    res_ready = 1'b1;
    step();
    chk("r5_rp1", read_pointer, 5'd31);
    wait_valid("r5b", 10, n);
    chk("r5b_val", res_value, -64'sd5);
    chk("r5b_ptr", res_ptr, 5'd31);
    step();
    chk("r5_rp2", read_pointer, 5'd0);
    wait_valid("r5c", 10, n);
    chk("r5c_val", res_value, 64'd0);
    chk("r5c_ptr", res_ptr, 5'd0);
    step();
    chk("r5_rp3", read_pointer, 5'd1);
    wait_valid("r5d", 10, n);
    chk("r5d_val", res_value, -64'sd2);
    step();
    chk("r5_done", done, 1'b1);
    step();

    // Reset during DIVWAIT
    kick(5'd10, 6'd1);
    for (int i = 0; i < 6; i++) step();
    chk("r6_in_div", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("r6_busy", busy, 1'b0);
    chk("r6_valid", res_valid, 1'b0);
    chk("r6_rp", read_pointer, 5'd10 & 5'd0);
    chk("r6_value", res_value, 64'd0);
    chk("r6_ptr", res_ptr, 5'd0);
    chk("r6_err", res_err, 1'b0);
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("r6_stays_idle", busy, 1'b0);
    chk("r6_no_valid", res_valid, 1'b0);

    // count = 0
    kick(5'd5, 6'd0);
    chk("r7_done", done, 1'b1);
    chk("r7_busy", busy, 1'b0);
    step();
    chk("r7_done_pulse", done, 1'b0);
    chk("r7_valid", res_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_exec_unit.md
# instr_exec_unit

Execute stage that sits directly downstream of the instruction register. On a `start` command it drives `read_pointer` to walk a contiguous run of stored instruction words. For each word it computes the operation's result, using a multi-cycle iterative divider for DIV/MOD. Each result is delivered on a valid/ready output port, so a stalled consumer back-pressures the whole run.

## Interface
- `DEPTH`, default 32: instruction register entries; power of 2, ≤ 32; pointer wraps modulo `DEPTH`.
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `start_ptr`  in  5 (`address_t`)  first entry of the run.
- `count`  in  6  number of instructions, 0..32.
- `read_pointer`  out  5 (`address_t`)  registered address to the instruction register.
- `instruction_word`  in  `instruction_t`  combinational read data {opc, op_a, op_b}.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_value`  out  64 signed  result.
- `res_opcode`  out  4 (`opcode_t`)  opcode that produced the result.
- `res_ptr`  out  5  entry that produced the result.
- `res_err`  out  1  result is invalid (divide by zero or illegal opcode).
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- FSM states: IDLE, FETCH, EXEC, DIVWAIT, OUT.
- **IDLE**
  - `start` with `count`≠0: load `read_pointer`←`start_ptr` and `remaining`←`count`, then go to FETCH.
  - `start` with `count`=0: pulse `done` on the next cycle and stay in IDLE.
- **FETCH:** register `instruction_word` into `iw_q`, then go to EXEC.
- **EXEC**
  - Single-cycle opcodes: load the result registers, then go to OUT.
  - DIV or MOD with op_b≠0: pulse `div_start`, then go to DIVWAIT.
- **DIVWAIT:** on `div_done`, load the result registers, then go to OUT.
- **OUT:** hold `res_valid` until `res_valid & res_ready`. On that handshake, decrement `remaining`.
  - `remaining` becomes 0: go to IDLE and pulse `done` in the same edge.
  - Otherwise: `read_pointer`←(`read_pointer`+1) mod `DEPTH`, go to FETCH.
- Opcode results, with operands sign-extended to 64 bits:
  - ZERO→0; PASSA→a; PASSB→b.
  - ADD→a+b; SUB→a−b; MULT→full 64-bit a*b.
  - DIV→quotient truncated toward zero.
  - MOD→remainder carrying the sign of a.
  - MIN_INT/−1→+2^31 with no error.
- Encodings 8–15 are illegal: `res_value`=0, `res_err`=1.
- `start` while `busy` is ignored.
- `res_*` outputs stay stable while `res_valid & !res_ready`.
- Reset values: state IDLE; every output, `iw_q`, `remaining` and divider state are 0.
- Reset mid-run aborts the run and the divider immediately.

## Timing
- `start` sampled at edge N gives `res_valid` high after edge N+2 for single-cycle opcodes.
- DIV/MOD: `div_start` at edge N+2, 32 iteration edges, capture at N+35, so `res_valid` is high after edge N+35.
- After the handshake edge M, the next `res_valid` rises after edge M+2. That gives a peak throughput of 1 result per 3 cycles.
- `done` is high for exactly the one cycle after the final handshake edge. `busy` drops in that same cycle.

## Configuration
- `DIV_ZERO_TRAP_EN` defined:
  - DIV/MOD with op_b=0 produces the result 0 with `res_err`=1, delivered through OUT.
  - After that handshake the run aborts: go to IDLE, pulse `done`, skip the remaining entries.
- Not defined:
  - Same errored result, 0 with `res_err`=1, with no divider start.
  - The run continues normally.

## Structure
- Shared package `instr_register_pkg` holds:
  - existing `opcode_t`, `operand_t`, `address_t`, `instruction_t`;
  - new `exec_state_t` enum and `result_t` (signed [63:0]).
- Sub-module `instr_divider`: signed restoring divider, 32 iterations.
  - Ports: `div_start`, operands, `quotient`, `remainder`, `div_done`.
  - Converts operands to magnitudes and fixes signs on output; asynchronous reset to 0.

## Test plan
- `start_ptr`=3, `count`=3, entries ADD 5+7, SUB 2−9, MULT −3*4, `res_ready`=1 → `res_value` 12, −7, −12; `res_ptr` 3, 4, 5; single `done`.
- DIV 7/−2 and MOD −7/2 → −3 and −1; `res_valid` rises 35 cycles after `start`.
- DIV 10/0 → 0 with `res_err`=1.
  - With `DIV_ZERO_TRAP_EN`, the run of 3 ends after 1 result.
  - Without it, all 3 results are delivered.
- `start_ptr`=30, `count`=4 → `read_pointer` sequence 30, 31, 0, 1; `res_ready` held low 5 cycles → outputs stable throughout.
- `reset_n` low during DIVWAIT → all outputs 0, IDLE. `start` while `busy` is ignored. `count`=0 → `done` pulse only.
